// File: rtl/reg_univ_pkg.sv
// Shared operation encodings for the universal register and its bench.
package reg_univ_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'd6;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'd7;

endpackage

// File: rtl/reg_univ_next.sv
// Combinational next-value datapath: next Q and next carry for each operation.
module reg_univ_next
    import reg_univ_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]  q,
    input  logic              carry,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  q_next,
    output logic              carry_next
);

    always_comb begin
        q_next     = q;
        carry_next = carry;
        case (mode)
            MODE_LOAD: begin
                q_next     = d;
                carry_next = 1'b0;
            end
            MODE_SHL: begin
                q_next     = {q[WIDTH-2:0], sin};
                carry_next = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next     = {sin, q[WIDTH-1:1]};
                carry_next = q[0];
            end
            MODE_ROL: begin
                q_next     = {q[WIDTH-2:0], q[WIDTH-1]};
                carry_next = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next     = {q[0], q[WIDTH-1:1]};
                carry_next = q[0];
            end
            // Wrap flags: all-ones rolls over on INC, zero rolls under on DEC.
            MODE_INC: begin
                q_next     = q + 1'b1;
                carry_next = &q;
            end
            MODE_DEC: begin
                q_next     = q - 1'b1;
                carry_next = ~|q;
            end
            default: begin
                q_next     = q;
                carry_next = carry;
            end
        endcase
    end

endmodule

// File: rtl/reg_univ_n.sv
// Universal N-bit register: load, shift, rotate, inc/dec with carry flag.
// Optional REG_UNIV_PARITY_EN adds a combinational odd-parity output of Q.
module reg_univ_n
    import reg_univ_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  D,
    input  logic              sin,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  Qn,
    output logic              carry,
`ifdef REG_UNIV_PARITY_EN
    output logic              parity,
`endif
    output logic              zero
);

    logic [WIDTH-1:0] q_q, q_d, q_op;
    logic             carry_q, carry_d, carry_op;

    reg_univ_next #(.WIDTH(WIDTH)) u_next (
        .q          (q_q),
        .carry      (carry_q),
        .d          (D),
        .sin        (sin),
        .mode       (mode),
        .q_next     (q_op),
        .carry_next (carry_op)
    );

    // Reset is handled in the register itself; set outranks the enabled operation.
    always_comb begin
        q_d     = q_q;
        carry_d = carry_q;
        if (set) begin
            q_d     = '1;
            carry_d = 1'b0;
        end else if (en) begin
            q_d     = q_op;
            carry_d = carry_op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q     <= RST_VAL;
            carry_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end

    assign Q     = q_q;
    assign Qn    = ~q_q;
    assign carry = carry_q;
    assign zero  = (q_q == '0);

`ifdef REG_UNIV_PARITY_EN
    assign parity = ^q_q;
`endif

endmodule

// File: doc/reg_univ_n.md
REG_UNIV_N -- requirements
Module: reg_univ_n

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; legal range 2..32.
REQ-002 Parameter RST_VAL, default 0, WIDTH-bit value loaded by reset.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port set, input, 1, synchronous active-high set; forces Q to all ones.
REQ-006 Port en, input, 1, clock enable; when low, Q and carry hold.
REQ-007 Port mode, input, 3, operation select (encodings in REQ-013).
REQ-008 Port D, input, WIDTH, parallel load data.
REQ-009 Port sin, input, 1, serial input for shift operations.
REQ-010 Port Q, output, WIDTH, registered value; Qn, output, WIDTH, bitwise complement of Q.
REQ-011 Port carry, output, 1, registered bit shifted out, or the wrap flag of INC/DEC.
REQ-012 Port zero, output, 1, combinational; high when Q == 0.

Function
REQ-013 mode encodings: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 INC, 7 DEC.
REQ-014 Priority per edge: reset > set > en-gated operation; no other combination is legal.
REQ-015 Latency: one cycle; the result of an operation is visible on Q after the edge that samples it.
REQ-016 HOLD: Q and carry unchanged.
REQ-017 LOAD: Q <= D; carry <= 0.
REQ-018 SHL: Q <= {Q[W-2:0], sin}; carry <= Q[W-1].
REQ-019 SHR: Q <= {sin, Q[W-1:1]}; carry <= Q[0].
REQ-020 ROL: Q <= {Q[W-2:0], Q[W-1]}; carry <= Q[W-1]; sin ignored.
REQ-021 ROR: Q <= {Q[0], Q[W-1:1]}; carry <= Q[0]; sin ignored.
REQ-022 INC: Q <= Q+1 modulo 2^WIDTH; carry <= 1 only when Q was all ones (wrap to 0), else 0.
REQ-023 DEC: Q <= Q-1 modulo 2^WIDTH; carry <= 1 only when Q was 0 (wrap to all ones), else 0.
REQ-024 en low with any mode: no state change, including carry.
REQ-025 set high: Q <= all ones, carry <= 0, regardless of en and mode.
REQ-026 Inputs sampled only at the rising clk edge; no asynchronous path to Q or carry.

Reset
REQ-027 reset high at an edge: Q <= RST_VAL, carry <= 0, regardless of set, en and mode; Qn = ~RST_VAL, zero = (RST_VAL == 0).
REQ-028 Reset asserted mid-sequence (e.g. during INC run) aborts it; the next operation starts from RST_VAL.

Configuration
REQ-029 Macro REG_UNIV_PARITY_EN defined: extra output parity, 1 bit, combinational XOR-reduction of Q (1 when Q has an odd number of ones).
REQ-030 Macro undefined: parity port and its logic absent; all other behaviour identical.

Structure
REQ-031 Package reg_univ_pkg holds the mode encodings (REQ-013) as named constants, shared with the bench.
REQ-032 One sub-module, reg_univ_next: purely combinational computation of next Q and next carry from Q, D, sin and mode; reg_univ_n holds only the registers and priority logic.

Verification (WIDTH=4, RST_VAL=0 unless stated)
REQ-033 reset=1 with set=1, en=1, mode=LOAD, D=1010 -> Q=0000, Qn=1111, carry=0, zero=1.
REQ-034 LOAD D=1001, then SHL sin=1 -> Q=0011, carry=1; then SHR sin=0 -> Q=0001, carry=1.
REQ-035 LOAD 1000, ROL x4 -> Q sequence 0001,0010,0100,1000; carry 1,0,0,0.
REQ-036 LOAD 1110, INC, INC -> Q=1111 carry=0, then Q=0000 carry=1, zero=1; DEC -> Q=1111 carry=1.
REQ-037 Q=0101, en=0, mode cycling all 8 values for 8 cycles -> Q=0101 and carry unchanged throughout; set=1 with en=0 -> Q=1111, carry=0.
REQ-038 RST_VAL=0110 build, INC run from 0000 interrupted by reset at Q=0011 -> Q=0110 next edge; with REG_UNIV_PARITY_EN, parity=0 for 0110 and 1 for 0111.
